// File: rtl/synth_pkg.sv
// Shared synthesizer definitions: octave keys owned by synthesizer_state and
// the voice allocator state encoding.
package synth_pkg;

   localparam logic [7:0] KEY_OCT_UP   = 8'h75;
   localparam logic [7:0] KEY_OCT_DOWN = 8'h72;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MATCH = 2'd1,
      ST_APPLY = 2'd2
   } alloc_state_e;

   // Octave arrows are consumed elsewhere and must never claim a voice.
   function automatic logic is_octave_key(input logic [7:0] code);
      return (code == KEY_OCT_UP) || (code == KEY_OCT_DOWN);
   endfunction

endpackage

// File: rtl/synth_prio_enc.sv
// Lowest-index priority encoder: reports the first set bit and whether any bit is set.
module synth_prio_enc #(
   parameter int W     = 4,
   parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]     vec,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Scan from the top down so the lowest set index is written last and wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/synth_voice_allocator.sv
// Voice allocator: maps key press/release events onto a fixed voice pool.
// Press policy: retrigger the voice holding the code, else lowest free voice,
// else steal the least-recently-allocated voice (rank NUM_VOICES-1).
//
// Handshake: an event transfers on a rising edge where ev_valid and ev_ready
// are both high; ev_ready is high only in IDLE with panic low, and the source
// must hold ev_valid/ev_on/ev_code stable until that edge.
module synth_voice_allocator
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int AGE_W      = $clog2(NUM_VOICES)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    ev_valid,
   output logic                    ev_ready,
   input  logic                    ev_on,
   input  logic [7:0]              ev_code,
   input  logic                    panic,
   output logic [NUM_VOICES-1:0]   voice_gate,
   output logic [8*NUM_VOICES-1:0] voice_code,
   output logic [NUM_VOICES-1:0]   voice_retrig,
   output logic                    busy
);

   alloc_state_e          state_q, state_d;
   logic                  lat_on_q, lat_on_d;
   logic [7:0]            lat_code_q, lat_code_d;
   logic [NUM_VOICES-1:0] gate_q, gate_d;
   logic [NUM_VOICES-1:0] retrig_q, retrig_d;
   logic [7:0]            code_q [NUM_VOICES];
   logic [7:0]            code_d [NUM_VOICES];
   logic [AGE_W-1:0]      rank_q [NUM_VOICES];
   logic [AGE_W-1:0]      rank_d [NUM_VOICES];

   // Registered MATCH results consumed in APPLY.
   logic                  hit_found_q, hit_found_d;
   logic [AGE_W-1:0]      hit_idx_q, hit_idx_d;
   logic                  free_found_q, free_found_d;
   logic [AGE_W-1:0]      free_idx_q, free_idx_d;
   logic [AGE_W-1:0]      old_idx_q, old_idx_d;

   logic [NUM_VOICES-1:0] hit_vec, free_vec;
   logic                  hit_found, free_found;
   logic [AGE_W-1:0]      hit_idx, free_idx, old_idx;
   logic [AGE_W-1:0]      sel_idx, sel_rank;

   // Per-voice compares against the latched code, and locate the oldest voice.
   always_comb begin
      hit_vec = '0;
      old_idx = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         hit_vec[i] = gate_q[i] && (code_q[i] == lat_code_q);
         if (rank_q[i] == AGE_W'(NUM_VOICES - 1)) begin
            old_idx = AGE_W'(i);
         end
      end
   end

   assign free_vec = ~gate_q;

   synth_prio_enc #(.W(NUM_VOICES), .IDX_W(AGE_W)) u_hit_enc (
      .vec   (hit_vec),
      .idx   (hit_idx),
      .found (hit_found)
   );

   synth_prio_enc #(.W(NUM_VOICES), .IDX_W(AGE_W)) u_free_enc (
      .vec   (free_vec),
      .idx   (free_idx),
      .found (free_found)
   );

   // Voice chosen for a press: hit, else free, else oldest.
   always_comb begin
      if (hit_found_q) begin
         sel_idx = hit_idx_q;
      end else if (free_found_q) begin
         sel_idx = free_idx_q;
      end else begin
         sel_idx = old_idx_q;
      end
      sel_rank = rank_q[sel_idx];
   end

   // Next-state and voice-table update for the IDLE -> MATCH -> APPLY sequence.
   always_comb begin
      state_d      = state_q;
      lat_on_d     = lat_on_q;
      lat_code_d   = lat_code_q;
      gate_d       = gate_q;
      retrig_d     = '0;
      code_d       = code_q;
      rank_d       = rank_q;
      hit_found_d  = hit_found_q;
      hit_idx_d    = hit_idx_q;
      free_found_d = free_found_q;
      free_idx_d   = free_idx_q;
      old_idx_d    = old_idx_q;

      case (state_q)
         ST_IDLE: begin
            if (panic) begin
               gate_d = '0;
            end else if (ev_valid) begin
               lat_on_d   = ev_on;
               lat_code_d = ev_code;
               state_d    = ST_MATCH;
            end
         end

         ST_MATCH: begin
            hit_found_d  = hit_found;
            hit_idx_d    = hit_idx;
            free_found_d = free_found;
            free_idx_d   = free_idx;
            old_idx_d    = old_idx;
            state_d      = ST_APPLY;
         end

         ST_APPLY: begin
            state_d = ST_IDLE;
            if (!is_octave_key(lat_code_q)) begin
               if (lat_on_q) begin
                  gate_d[sel_idx]   = 1'b1;
                  code_d[sel_idx]   = lat_code_q;
                  retrig_d[sel_idx] = 1'b1;
                  // Move the chosen voice to the front; younger voices age by one.
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     if (AGE_W'(i) == sel_idx) begin
                        rank_d[i] = '0;
                     end else if (rank_q[i] < sel_rank) begin
                        rank_d[i] = rank_q[i] + AGE_W'(1);
                     end
                  end
               end else if (hit_found_q) begin
                  gate_d[hit_idx_q] = 1'b0;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous reset; ranks restart as 0..N-1.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         lat_on_q     <= 1'b0;
         lat_code_q   <= '0;
         gate_q       <= '0;
         retrig_q     <= '0;
         hit_found_q  <= 1'b0;
         hit_idx_q    <= '0;
         free_found_q <= 1'b0;
         free_idx_q   <= '0;
         old_idx_q    <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            code_q[i] <= '0;
            rank_q[i] <= AGE_W'(i);
         end
      end else begin
         state_q      <= state_d;
         lat_on_q     <= lat_on_d;
         lat_code_q   <= lat_code_d;
         gate_q       <= gate_d;
         retrig_q     <= retrig_d;
         hit_found_q  <= hit_found_d;
         hit_idx_q    <= hit_idx_d;
         free_found_q <= free_found_d;
         free_idx_q   <= free_idx_d;
         old_idx_q    <= old_idx_d;
         code_q       <= code_d;
         rank_q       <= rank_d;
      end
   end

   // Flatten the per-voice code table onto the output bus.
   always_comb begin
      voice_code = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         voice_code[8*i +: 8] = code_q[i];
      end
   end

   assign ev_ready     = (state_q == ST_IDLE) && !panic;
   assign busy         = (state_q != ST_IDLE);
   assign voice_gate   = gate_q;
   assign voice_retrig = retrig_q;

endmodule

// File: tb/tb_synth_voice_allocator.sv
// Bench for synth_voice_allocator: driver issues events, a reference model
// predicts the voice table, and a monitor compares two cycles after accept.
module tb_synth_voice_allocator;

   localparam int N     = 4;
   localparam int EXP_W = N + 8 * N + N;

   logic           clock;
   logic           reset;
   logic           ev_valid;
   logic           ev_ready;
   logic           ev_on;
   logic [7:0]     ev_code;
   logic           panic;
   logic [N-1:0]   voice_gate;
   logic [8*N-1:0] voice_code;
   logic [N-1:0]   voice_retrig;
   logic           busy;

   synth_voice_allocator #(.NUM_VOICES(N)) dut (
      .clock        (clock),
      .reset        (reset),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_on        (ev_on),
      .ev_code      (ev_code),
      .panic        (panic),
      .voice_gate   (voice_gate),
      .voice_code   (voice_code),
      .voice_retrig (voice_retrig),
      .busy         (busy)
   );

   // Clock and global watchdog.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: voice table plus an allocation-order list (front = newest).
   logic       m_gate [N];
   logic [7:0] m_code [N];
   int         m_order[$];
   logic [EXP_W-1:0] exp_q[$];

   function automatic void model_reset();
      m_order.delete();
      for (int i = 0; i < N; i++) begin
         m_gate[i] = 1'b0;
         m_code[i] = 8'h00;
         m_order.push_back(i);
      end
   endfunction

   function automatic logic [EXP_W-1:0] model_event(input logic on, input logic [7:0] code);
      logic [N-1:0]   g;
      logic [8*N-1:0] c;
      logic [N-1:0]   r;
      int             sel;
      r   = '0;
      sel = -1;
      if (code != 8'h75 && code != 8'h72) begin
         for (int i = 0; i < N; i++)
            if (sel < 0 && m_gate[i] && m_code[i] == code) sel = i;
         if (on) begin
            for (int i = 0; i < N; i++)
               if (sel < 0 && !m_gate[i]) sel = i;
            if (sel < 0) sel = m_order[m_order.size() - 1];
            m_gate[sel] = 1'b1;
            m_code[sel] = code;
            r[sel]      = 1'b1;
            for (int k = 0; k < m_order.size(); k++) begin
               if (m_order[k] == sel) begin
                  m_order.delete(k);
                  break;
               end
            end
            m_order.push_front(sel);
         end else if (sel >= 0) begin
            m_gate[sel] = 1'b0;
         end
      end
      for (int i = 0; i < N; i++) begin
         g[i]        = m_gate[i];
         c[8*i +: 8] = m_code[i];
      end
      return {g, c, r};
   endfunction

   function automatic logic [8*N-1:0] model_codes();
      logic [8*N-1:0] c;
      for (int i = 0; i < N; i++) c[8*i +: 8] = m_code[i];
      return c;
   endfunction

   // Monitor: an accept seen at a falling edge is checked three falling edges later,
   // and the retrigger pulse must be gone one cycle after that.
   int cyc = 0;
   int due_q[$];
   int zero_q[$];

   initial begin
      logic [EXP_W-1:0] e;
      forever begin
         @(negedge clock);
         cyc++;
         if (reset) begin
            due_q.delete();
            zero_q.delete();
            exp_q.delete();
         end else begin
            if (zero_q.size() > 0 && zero_q[0] == cyc) begin
               void'(zero_q.pop_front());
               check("retrig_one_cycle", 64'(voice_retrig), 64'(0));
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
               void'(due_q.pop_front());
               if (exp_q.size() == 0) begin
                  check("sb_expect_present", 64'(0), 64'(1));
               end else begin
                  e = exp_q.pop_front();
                  check("sb_gate", 64'(voice_gate), 64'(e[EXP_W-1 -: N]));
                  check("sb_code", 64'(voice_code), 64'(e[N +: 8*N]));
                  check("sb_retrig", 64'(voice_retrig), 64'(e[N-1:0]));
               end
               zero_q.push_back(cyc + 1);
            end
            if (ev_valid && ev_ready) due_q.push_back(cyc + 3);
         end
      end
   end

   // Driver tasks.
   task automatic do_reset(input int pre_cycles);
      repeat (pre_cycles) @(posedge clock);
      #1;
      reset    = 1'b1;
      ev_valid = 1'b0;
      panic    = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("reset_gate", 64'(voice_gate), 64'(0));
      check("reset_code", 64'(voice_code), 64'(0));
      check("reset_retrig", 64'(voice_retrig), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      reset = 1'b0;
      model_reset();
      @(negedge clock);
      check("ready_after_reset", 64'(ev_ready), 64'(1));
      check("idle_after_reset", 64'(busy), 64'(0));
   endtask

   task automatic send_event(input logic on, input logic [7:0] code);
      int waited;
      waited = 0;
      @(posedge clock);
      #1;
      ev_valid = 1'b1;
      ev_on    = on;
      ev_code  = code;
      @(negedge clock);
      while (!ev_ready && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      if (!ev_ready) begin
         check("accept_timeout", 64'(0), 64'(1));
      end else begin
         exp_q.push_back(model_event(on, code));
      end
      @(posedge clock);
      #1;
      ev_valid = 1'b0;
      ev_on    = 1'($urandom_range(0, 1));
      ev_code  = 8'($urandom_range(0, 255));
   endtask

   // One-cycle panic while idle, with an event offered that must be refused.
   task automatic do_panic();
      repeat (2) @(posedge clock);
      #1;
      panic    = 1'b1;
      ev_valid = 1'b1;
      ev_on    = 1'b1;
      ev_code  = 8'h3C;
      @(negedge clock);
      check("panic_ready_low", 64'(ev_ready), 64'(0));
      for (int i = 0; i < N; i++) m_gate[i] = 1'b0;
      @(posedge clock);
      #1;
      panic    = 1'b0;
      ev_valid = 1'b0;
      @(negedge clock);
      check("panic_gate", 64'(voice_gate), 64'(0));
      check("panic_code_kept", 64'(voice_code), 64'(model_codes()));
   endtask

   logic [7:0] code_pool [8];

   initial begin
      int r;
      code_pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h2D, 8'h34, 8'h75, 8'h72};
      reset    = 1'b1;
      ev_valid = 1'b0;
      ev_on    = 1'b0;
      ev_code  = 8'h00;
      panic    = 1'b0;
      model_reset();
      do_reset(2);

      // Single press lands on voice 0.
      send_event(1'b1, 8'h1C);

      // Fill the pool, then steal the oldest.
      do_reset(4);
      send_event(1'b1, 8'h1C);
      send_event(1'b1, 8'h1B);
      send_event(1'b1, 8'h23);
      send_event(1'b1, 8'h2B);
      send_event(1'b1, 8'h2D);

      // Repeated press retriggers the same voice.
      do_reset(4);
      send_event(1'b1, 8'h1C);
      send_event(1'b1, 8'h1C);

      // Release of a held note, then release of an unheld one.
      do_reset(4);
      send_event(1'b1, 8'h1C);
      send_event(1'b0, 8'h1C);
      send_event(1'b0, 8'h1B);

      // Panic with all voices held; a later press reuses voice 0.
      do_reset(4);
      send_event(1'b1, 8'h1C);
      send_event(1'b1, 8'h1B);
      send_event(1'b1, 8'h23);
      send_event(1'b1, 8'h2B);
      do_panic();
      send_event(1'b1, 8'h3C);

      // Octave key leaves voices alone; reset aborts a press during MATCH.
      do_reset(4);
      send_event(1'b1, 8'h75);
      repeat (2) @(posedge clock);
      #1;
      ev_valid = 1'b1;
      ev_on    = 1'b1;
      ev_code  = 8'h1C;
      @(negedge clock);
      check("ready_before_abort", 64'(ev_ready), 64'(1));
      @(posedge clock);
      #1;
      ev_valid = 1'b0;
      do_reset(0);
      send_event(1'b1, 8'h1B);
      send_event(1'b1, 8'h23);
      send_event(1'b1, 8'h2B);
      send_event(1'b1, 8'h34);
      send_event(1'b1, 8'h2D);

      // Randomized traffic with occasional panic.
      do_reset(4);
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            do_panic();
         end else begin
            send_event((r > 3) ? 1'b1 : 1'b0, code_pool[$urandom_range(0, 7)]);
         end
         repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
         end
      end

      repeat (10) @(posedge clock);
      check("sb_drained", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/synth_voice_allocator.md
Name: synth_voice_allocator

Overview:
- Shares a fixed pool of synthesizer voices between keyboard note events: press/release events in, per-voice gate/note/retrigger out.
- Sits between the keyboard decoder (key code + on/off) and the per-voice oscillator/ADSR instances configured by synthesizer_state.
- Policy on a press:
  - retrigger the voice already playing that code; otherwise
  - take the lowest-index free voice; otherwise
  - steal the least-recently-allocated voice.

Parameters:
- NUM_VOICES, 4, voice pool size; 2..8.
- AGE_W, $clog2(NUM_VOICES), width of the per-voice LRU rank.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high; all state cleared on the clock edge where it is high.
- ev_valid  in  1  note event offered.
- ev_ready  out  1  allocator accepts event this cycle.
- ev_on  in  1  1 = key press, 0 = key release.
- ev_code  in  8  key scan code.
- panic  in  1  all-notes-off request, level-sampled.
- voice_gate  out  NUM_VOICES  gate per voice, to ADSR.
- voice_code  out  8*NUM_VOICES  note code per voice; voice i at [8i+7:8i].
- voice_retrig  out  NUM_VOICES  one-cycle pulse when voice i starts or restarts a note.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - voice_gate = 0, voice_code = 0, voice_retrig = 0, busy = 0, ev_ready = 1 in the cycle after reset deasserts.
  - rank[i] = i, so voice NUM_VOICES-1 is the oldest.
- FSM states IDLE -> MATCH -> APPLY -> IDLE.
- IDLE:
  - ev_ready = 1 only when panic = 0.
  - ev_valid & ev_ready: latch ev_on/ev_code, go to MATCH.
  - panic = 1 has priority: all voice_gate <= 0 next edge; codes and ranks unchanged; event not accepted.
- MATCH (combinational compares, result registered):
  - hit_vec = gate & (code == latched code);
  - free_vec = ~gate;
  - lowest-index selection over each vector;
  - oldest = voice whose rank == NUM_VOICES-1.
- APPLY, press:
  - Hit on voice h: retrig[h] pulses; code unchanged.
  - Else free voice f: gate[f] <= 1, code[f] <= latched code, retrig[f] pulses.
  - Else steal oldest o: code[o] <= latched code, gate stays 1, retrig[o] pulses.
  - The chosen voice's rank <= 0; every voice whose rank was below the chosen voice's old rank increments. Ranks remain a permutation of 0..N-1.
- APPLY, release:
  - Hit on h: gate[h] <= 0; code and rank unchanged.
  - No hit: no change.
- Reserved codes 8'h75 and 8'h72 (octave up/down arrows, owned by synthesizer_state):
  - accepted in IDLE;
  - FSM returns to IDLE without touching any voice; no retrig.
- Timing:
  - Latency from accept edge to gate/retrig visible: 2 cycles.
  - Throughput: one event per 3 cycles.
  - voice_retrig is high exactly during the cycle after APPLY.
- Hit vector with more than one bit set is impossible by construction; if it occurs, lowest index wins.
- panic asserted while in MATCH/APPLY:
  - the in-flight event completes;
  - panic is honoured on the following IDLE cycle.
- reset mid-operation: in-flight event discarded, all outputs to reset values on that edge.
- ev_code and ev_on are ignored when not accepted; no buffering, so the upstream side holds ev_valid until ev_ready.

Decomposition:
- Shared package synth_pkg holds:
  - KEY_OCT_UP = 8'h75 and KEY_OCT_DOWN = 8'h72 (also used by the octave logic);
  - the allocator state encoding IDLE/MATCH/APPLY (2 bits).
- One sub-module, synth_prio_enc: parameterised lowest-index priority encoder (vector in -> index + found). Instantiated for hit_vec and free_vec.

Test Plan:
- Reset, then press 8'h1C -> 2 cycles later gate = 4'b0001, code0 = 8'h1C, retrig = 4'b0001 for one cycle, rank0 = 0, rank1..3 = 1,2,3.
- Press 8'h1C, 8'h1B, 8'h23, 8'h2B, then 8'h2D -> first four fill voices 0..3; 8'h2D steals voice 0 (oldest) → code0 = 8'h2D, gate stays 4'b1111, retrig = 4'b0001.
- Press 8'h1C, press 8'h1C again -> no new voice; retrig0 pulses twice; gate = 4'b0001.
- Press 8'h1C, release 8'h1C, release 8'h1B -> gate0 falls 2 cycles after the first release; the second release changes nothing.
- Hold 4 voices, assert panic one cycle in IDLE with ev_valid = 1 -> ev_ready = 0 that cycle; gate = 4'b0000 next edge; event accepted afterwards.
- Press 8'h75, then assert reset during MATCH of a following press -> no voice changes for 8'h75; after reset all outputs are zero and rank = 0,1,2,3.
